// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH,
        TRAP
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} entries; flush clears it, simultaneous push/pop when full is allowed.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads imem, queues {pc, instr} for decode.
// Optional FETCH_PERF_CNT_EN adds push/redirect performance counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
    output logic        o_if_valid,
    input  logic        i_if_ready,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_fetch_cnt,
    output logic [31:0] o_perf_flush_cnt
`endif
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_misalign_err;
    logic            w_err_next;
    fetch_entry_t    r_last_head;

    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;

    assign w_entry = '{pc: r_pc, instr: i_imem_rdata};
    assign w_pop   = !w_empty && i_if_ready;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_err_next   = r_misalign_err;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            FETCH: begin
                if (i_redirect_valid) begin
                    w_pc_next = i_redirect_target;
                    w_flush   = 1'b1;
                    if (is_misaligned(i_redirect_target)) begin
                        w_err_next   = 1'b1;
                        w_state_next = TRAP;
                    end
                end else if (!i_stall && (!w_full || w_pop)) begin
                    w_push    = 1'b1;
                    w_pc_next = r_pc + XLEN'(INSTR_BYTES);
                end
            end
            TRAP: begin
                if (i_redirect_valid) begin
                    w_pc_next = i_redirect_target;
                    w_flush   = 1'b1;
                    if (!is_misaligned(i_redirect_target)) begin
                        w_err_next   = 1'b0;
                        w_state_next = FETCH;
                    end
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= FETCH;
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
            r_last_head    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_misalign_err <= w_err_next;
            // Remember the visible head so outputs hold once the queue drains.
            if (!w_empty) begin
                r_last_head <= w_head;
            end
        end
    end

    assign o_imem_addr    = r_pc;
    assign o_if_valid     = !w_empty;
    assign o_if_pc        = w_empty ? r_last_head.pc : w_head.pc;
    assign o_if_instr     = w_empty ? r_last_head.instr : w_head.instr;
    assign o_misalign_err = r_misalign_err;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (i_redirect_valid) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; perf checks need FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    // Address-tagged instruction memory.
    assign imem_rdata = imem_addr ^ TAG;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .o_imem_addr       (imem_addr),
        .i_imem_rdata      (imem_rdata),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_if_valid        (if_valid),
        .i_if_ready        (if_ready),
        .o_if_pc           (if_pc),
        .o_if_instr        (if_instr),
        .o_misalign_err    (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetch_cnt  (perf_fetch_cnt),
        .o_perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if_ready        = 1'b1;
        #2;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // 1: streaming with decode always ready
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_instr0", if_instr, 32'h0 ^ TAG);
        chk("t1_valid0", {31'b0, if_valid}, 32'd1);
        tick();
        chk("t1_pc4", if_pc, 32'h4);
        chk("t1_valid4", {31'b0, if_valid}, 32'd1);
        tick();
        chk("t1_pc8", if_pc, 32'h8);
        tick();
        chk("t1_pc12", if_pc, 32'hC);
        chk("t1_instr12", if_instr, 32'hC ^ TAG);

        // 2: backpressure fills the queue, then drains in order
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("t2_addr_stop", imem_addr, 32'h8);
        chk("t2_head_hold", if_pc, 32'h0);
        chk("t2_valid", {31'b0, if_valid}, 32'd1);
        if_ready = 1'b1;
        tick();
        chk("t2_pc4", if_pc, 32'h4);
        tick();
        chk("t2_pc8", if_pc, 32'h8);
        tick();
        chk("t2_pc12", if_pc, 32'hC);
        chk("t2_addr", imem_addr, 32'h14);

        // 3: aligned redirect with full queue and active pop
        redirect_valid  = 1'b1;
        redirect_target = 32'h2C;
        tick();
        redirect_valid = 1'b0;
        chk("t3_empty", {31'b0, if_valid}, 32'd0);
        chk("t3_hold_pc", if_pc, 32'hC);
        chk("t3_addr", imem_addr, 32'h2C);
        tick();
        chk("t3_pc", if_pc, 32'h2C);
        chk("t3_instr", if_instr, 32'h2C ^ TAG);
        chk("t3_valid", {31'b0, if_valid}, 32'd1);

        // 4: misaligned redirect traps until an aligned redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h32;
        tick();
        redirect_valid = 1'b0;
        chk("t4_err", {31'b0, misalign_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_trap_valid", {31'b0, if_valid}, 32'd0);
            tick();
        end
        chk("t4_trap_addr", imem_addr, 32'h32);
        redirect_valid  = 1'b1;
        redirect_target = 32'h33;
        tick();
        chk("t4_retrap_err", {31'b0, misalign_err}, 32'd1);
        chk("t4_retrap_addr", imem_addr, 32'h33);
        redirect_target = 32'h10;
        tick();
        redirect_valid = 1'b0;
        chk("t4_clr_err", {31'b0, misalign_err}, 32'd0);
        chk("t4_clr_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("t4_pc", if_pc, 32'h10);
        chk("t4_valid", {31'b0, if_valid}, 32'd1);

        // 5: PC wrap and stall with pending entries
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_addr", imem_addr, 32'h0);
        tick();
        chk("t5_wrap_pc", if_pc, 32'h0);
        chk("t5_wrap_instr", if_instr, TAG);
        if_ready = 1'b0;
        tick();
        stall    = 1'b1;
        if_ready = 1'b1;
        tick();
        chk("t5_stall_pc", if_pc, 32'h4);
        chk("t5_stall_addr", imem_addr, 32'h8);
        chk("t5_stall_valid", {31'b0, if_valid}, 32'd1);
        tick();
        chk("t5_drain_valid", {31'b0, if_valid}, 32'd0);
        chk("t5_drain_hold", if_pc, 32'h4);
        chk("t5_drain_addr", imem_addr, 32'h8);
        stall = 1'b0;

        // 6: counters (when present) and reset mid-run
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 32'd7);
        chk("t6_perf_flush", perf_flush_cnt, 32'd2);
`endif
        if_ready = 1'b0;
        tick();
        tick();
        chk("t6_full_valid", {31'b0, if_valid}, 32'd1);
        chk("t6_full_head", if_pc, 32'h40);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'b0, if_valid}, 32'd0);
        chk("t6_rst_pc", if_pc, 32'h0);
        chk("t6_rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("t6_rst_flush", perf_flush_cnt, 32'd0);
`endif
        tick();
        reset    = 1'b0;
        if_ready = 1'b1;
        tick();
        chk("t6_restart_pc", if_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
